// File: rtl/pe_row_conv_engine.sv
// pe_row_conv_engine: row-convolution engine for the PE datapath.
// Captures one tagged IFMap row into a scratchpad, then slides the filter
// across it one tap per cycle and emits one psum per complete window.
// Optional feature macro: PSUM_SATURATE_EN (ps_data_o saturates instead of wrapping).
//
// state | meaning
// IDLE  | waiting for start_i; filter writes land here only
// SEEK  | discarding IFMap words until a row-start tag
// LOAD  | filling the row scratchpad until the row-end tag
// MAC   | one tap per cycle for the window at base_q
// OUT   | presenting the window psum until ps_ready_i
// NEXT  | row finished; count it, then end the job or seek the next row
module pe_row_conv_engine #(
    parameter int DATA_W     = 16,
    parameter int PSUM_W     = 16,
    parameter int ROW_MAX    = 16,
    parameter int FILTER_MAX = 9,
    parameter int STRIDE_W   = 3,
    parameter int FSIZE_W    = 4,
    parameter int ROWS_W     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [STRIDE_W-1:0]           stride_i,
    input  logic [FSIZE_W-1:0]            filter_size_i,
    input  logic [ROWS_W-1:0]             num_rows_i,
    input  logic                          filt_wen_i,
    input  logic [$clog2(FILTER_MAX)-1:0] filt_addr_i,
    input  logic [DATA_W-1:0]             filt_data_i,
    input  logic                          if_valid_i,
    output logic                          if_ready_o,
    input  logic [DATA_W+1:0]             if_data_i,
    output logic                          ps_valid_o,
    input  logic                          ps_ready_i,
    output logic [PSUM_W-1:0]             ps_data_o,
    output logic                          ps_last_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          ovf_err_o
);

    localparam int FA_W   = $clog2(FILTER_MAX);
    localparam int SA_W   = $clog2(ROW_MAX);
    localparam int LEN_W  = $clog2(ROW_MAX + 1);
    // wide enough for base + stride + filter_size without wrapping
    localparam int POS_W  = $clog2(ROW_MAX + (1 << STRIDE_W) + FILTER_MAX + 1);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + FA_W;

    typedef enum logic [2:0] {
        S_IDLE, S_SEEK, S_LOAD, S_MAC, S_OUT, S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [FSIZE_W-1:0]  fs_q, fs_d;
    logic [ROWS_W-1:0]   rows_q, rows_d;
    logic [ROWS_W-1:0]   row_cnt_q, row_cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [POS_W-1:0]    base_q, base_d;
    logic [FSIZE_W-1:0]  k_q, k_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   spad_q [ROW_MAX];
    logic [DATA_W-1:0]   filt_q [FILTER_MAX];

    logic                spad_we;
    logic [SA_W-1:0]     spad_wa;
    logic [1:0]          tag;
    logic [DATA_W-1:0]   word;
    logic [POS_W-1:0]    win_end, next_end, tap_pos;
    logic [SA_W-1:0]     tap_idx;
    logic [FA_W-1:0]     tap_k;
    logic [PROD_W-1:0]   prod;
    logic [ROWS_W-1:0]   row_inc;
    logic                row_fits, last_win, last_tap, len_full;
    logic                unused_bits;

    assign tag      = if_data_i[DATA_W+1:DATA_W];
    assign word     = if_data_i[DATA_W-1:0];
    assign win_end  = base_q + POS_W'(fs_q);
    assign next_end = win_end + POS_W'(stride_q);
    assign tap_pos  = base_q + POS_W'(k_q);
    assign tap_idx  = tap_pos[SA_W-1:0];
    assign tap_k    = k_q[FA_W-1:0];
    assign prod     = PROD_W'(spad_q[tap_idx]) * PROD_W'(filt_q[tap_k]);
    assign row_inc  = row_cnt_q + 1'b1;
    assign row_fits = (win_end <= POS_W'(len_q));
    assign last_win = (next_end > POS_W'(len_q));
    assign last_tap = (k_q == fs_q - 1'b1);
    assign len_full = (len_q == LEN_W'(ROW_MAX));
    assign unused_bits = ^tap_pos[POS_W-1:SA_W];

    // Next-state, datapath updates and scratchpad write strobe.
    always_comb begin
        state_d   = state_q;
        stride_d  = stride_q;
        fs_d      = fs_q;
        rows_d    = rows_q;
        row_cnt_d = row_cnt_q;
        len_d     = len_q;
        base_d    = base_q;
        k_d       = k_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        spad_we   = 1'b0;
        spad_wa   = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    stride_d = (stride_i == '0) ? STRIDE_W'(1) : stride_i;
                    if (filter_size_i == '0)
                        fs_d = FSIZE_W'(1);
                    else if (filter_size_i > FSIZE_W'(FILTER_MAX))
                        fs_d = FSIZE_W'(FILTER_MAX);
                    else
                        fs_d = filter_size_i;
                    rows_d    = (num_rows_i == '0) ? ROWS_W'(1) : num_rows_i;
                    row_cnt_d = '0;
                    ovf_d     = 1'b0;
                    len_d     = '0;
                    base_d    = '0;
                    k_d       = '0;
                    state_d   = S_SEEK;
                end
            end
            S_SEEK: begin
                if (if_valid_i && tag[1]) begin
                    spad_we = 1'b1;
                    len_d   = LEN_W'(1);
                    base_d  = '0;
                    k_d     = '0;
                    state_d = tag[0] ? S_MAC : S_LOAD;
                end
            end
            S_LOAD: begin
                if (if_valid_i) begin
                    if (tag[1]) begin
                        // a new start tag abandons the partial row
                        spad_we = 1'b1;
                        len_d   = LEN_W'(1);
                        base_d  = '0;
                        k_d     = '0;
                        state_d = tag[0] ? S_MAC : S_LOAD;
                    end else begin
                        if (len_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            spad_we = 1'b1;
                            spad_wa = len_q[SA_W-1:0];
                            len_d   = len_q + 1'b1;
                        end
                        if (tag[0]) begin
                            base_d  = '0;
                            k_d     = '0;
                            state_d = S_MAC;
                        end
                    end
                end
            end
            S_MAC: begin
                if (k_q == '0 && !row_fits) begin
                    state_d = S_NEXT;
                end else begin
                    acc_d = ((k_q == '0) ? ACC_W'(0) : acc_q) + ACC_W'(prod);
                    if (last_tap) begin
                        k_d     = '0;
                        state_d = S_OUT;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (ps_ready_i) begin
                    // last window skips the MAC fit check and closes the row directly
                    base_d  = base_q + POS_W'(stride_q);
                    state_d = last_win ? S_NEXT : S_MAC;
                end
            end
            S_NEXT: begin
                row_cnt_d = row_inc;
                len_d     = '0;
                base_d    = '0;
                state_d   = (row_inc == rows_q) ? S_IDLE : S_SEEK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            stride_q  <= STRIDE_W'(1);
            fs_q      <= FSIZE_W'(1);
            rows_q    <= ROWS_W'(1);
            row_cnt_q <= '0;
            len_q     <= '0;
            base_q    <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stride_q  <= stride_d;
            fs_q      <= fs_d;
            rows_q    <= rows_d;
            row_cnt_q <= row_cnt_d;
            len_q     <= len_d;
            base_q    <= base_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    // Scratchpads carry no reset; filter taps persist across jobs and resets.
    always_ff @(posedge clk_i) begin
        if (filt_wen_i && state_q == S_IDLE && ({1'b0, filt_addr_i} < (FA_W + 1)'(FILTER_MAX)))
            filt_q[filt_addr_i] <= filt_data_i;
        if (spad_we)
            spad_q[spad_wa] <= word;
    end

    assign if_ready_o = (state_q == S_SEEK) || (state_q == S_LOAD);
    assign ps_valid_o = (state_q == S_OUT);
    assign ps_last_o  = (state_q == S_OUT) && last_win;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_NEXT) && (row_inc == rows_q);
    assign ovf_err_o  = ovf_q;

`ifdef PSUM_SATURATE_EN
    assign ps_data_o = (|acc_q[ACC_W-1:PSUM_W]) ? {PSUM_W{1'b1}} : acc_q[PSUM_W-1:0];
`else
    assign ps_data_o = acc_q[PSUM_W-1:0];
`endif

endmodule

// File: tb/tb_pe_row_conv_engine.sv
// Bench for pe_row_conv_engine: directed scenarios plus randomized jobs
// checked against a window-sum reference model built from the row contents.
module tb_pe_row_conv_engine;

    localparam int DATA_W     = 16;
    localparam int PSUM_W     = 16;
    localparam int ROW_MAX    = 16;
    localparam int FILTER_MAX = 9;
    localparam int STRIDE_W   = 3;
    localparam int FSIZE_W    = 4;
    localparam int ROWS_W     = 8;
    localparam int FA_W       = $clog2(FILTER_MAX);
    localparam int BUDGET     = 4000;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic                start_i = 1'b0;
    logic [STRIDE_W-1:0] stride_i = '0;
    logic [FSIZE_W-1:0]  filter_size_i = '0;
    logic [ROWS_W-1:0]   num_rows_i = '0;
    logic                filt_wen_i = 1'b0;
    logic [FA_W-1:0]     filt_addr_i = '0;
    logic [DATA_W-1:0]   filt_data_i = '0;
    logic                if_valid_i = 1'b0;
    logic                if_ready_o;
    logic [DATA_W+1:0]   if_data_i = '0;
    logic                ps_valid_o;
    logic                ps_ready_i = 1'b1;
    logic [PSUM_W-1:0]   ps_data_o;
    logic                ps_last_o;
    logic                busy_o;
    logic                done_o;
    logic                ovf_err_o;

    pe_row_conv_engine dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stride_i(stride_i),
        .filter_size_i(filter_size_i), .num_rows_i(num_rows_i),
        .filt_wen_i(filt_wen_i), .filt_addr_i(filt_addr_i), .filt_data_i(filt_data_i),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_data_i(if_data_i),
        .ps_valid_o(ps_valid_o), .ps_ready_i(ps_ready_i), .ps_data_o(ps_data_o),
        .ps_last_o(ps_last_o), .busy_o(busy_o), .done_o(done_o), .ovf_err_o(ovf_err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_stride, m_fs, m_rows;
    int filt_m [FILTER_MAX];
    int exp_data [$];
    bit exp_last [$];
    bit exp_ovf;
    logic [DATA_W+1:0] words [$];

    // observations from the last job
    int got_data [$];
    bit got_last [$];
    int got_cyc [$];
    int done_cnt, done_cyc, last_acc_cyc, stall_bad, stall_ref;
    bit timeout;

    function automatic void model_row(input int row[$]);
        int n;
        n = (row.size() > ROW_MAX) ? ROW_MAX : row.size();
        if (row.size() > ROW_MAX) exp_ovf = 1'b1;
        for (int b = 0; b + m_fs <= n; b += m_stride) begin
            longint s = 0;
            for (int k = 0; k < m_fs; k++)
                s += longint'(row[b+k]) * longint'(filt_m[k]);
`ifdef PSUM_SATURATE_EN
            if (s > (longint'(1) << PSUM_W) - 1) s = (longint'(1) << PSUM_W) - 1;
`else
            s = s % (longint'(1) << PSUM_W);
`endif
            exp_data.push_back(int'(s));
            exp_last.push_back(b + m_stride + m_fs > n);
        end
    endfunction

    function automatic void push_row(input int row[$]);
        logic [1:0] tg;
        if (row.size() == 1) begin
            words.push_back({2'b11, DATA_W'(row[0])});
        end else begin
            for (int i = 0; i < row.size(); i++) begin
                tg = (i == 0) ? 2'b10 : ((i == row.size() - 1) ? 2'b01 : 2'b00);
                words.push_back({tg, DATA_W'(row[i])});
            end
        end
        model_row(row);
    endfunction

    task automatic write_filt(input int addr, input int val);
        filt_wen_i  = 1'b1;
        filt_addr_i = FA_W'(addr);
        filt_data_i = DATA_W'(val);
        @(negedge clk_i);
        filt_wen_i  = 1'b0;
    endtask

    task automatic load_filt(input int addr, input int val);
        write_filt(addr, val);
        filt_m[addr] = val;
    endtask

    task automatic do_start(input int s, input int f, input int r);
        stride_i      = STRIDE_W'(s);
        filter_size_i = FSIZE_W'(f);
        num_rows_i    = ROWS_W'(r);
        start_i       = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
        m_stride = (s == 0) ? 1 : s;
        m_fs     = (f == 0) ? 1 : ((f > FILTER_MAX) ? FILTER_MAX : f);
        m_rows   = (r == 0) ? 1 : r;
        exp_data.delete();
        exp_last.delete();
        exp_ovf = 1'b0;
        words.delete();
    endtask

    // Feeds the word queue and collects psums concurrently.
    // rmode 0: ps_ready always high; 1: random; 2: 3 low cycles on first OUT.
    task automatic run_job(input int rmode, input bit gaps);
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        done_cnt = 0; done_cyc = -1; last_acc_cyc = -1;
        stall_bad = 0; stall_ref = -1; timeout = 1'b0;
        fork
            begin
                int n;
                for (int i = 0; i < words.size(); i++) begin
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        if_valid_i = 1'b0;
                        @(negedge clk_i);
                    end
                    if_valid_i = 1'b1;
                    if_data_i  = words[i];
                    n = 0;
                    while (!if_ready_o && n < BUDGET) begin
                        @(negedge clk_i);
                        n++;
                    end
                    if (n >= BUDGET) begin
                        timeout = 1'b1;
                        break;
                    end
                    last_acc_cyc = cyc;
                    @(negedge clk_i);
                end
                if_valid_i = 1'b0;
            end
            begin
                int tail, stalls;
                bit seen_out;
                tail = 0; stalls = 0; seen_out = 1'b0;
                for (int n = 0; n < BUDGET; n++) begin
                    case (rmode)
                        1: ps_ready_i = ($urandom_range(0, 3) != 0);
                        2: begin
                            if (ps_valid_o && !seen_out) begin
                                if (stalls == 0) stall_ref = int'(ps_data_o);
                                else if (int'(ps_data_o) != stall_ref) stall_bad++;
                                if (if_ready_o !== 1'b0) stall_bad++;
                                if (stalls < 3) begin
                                    ps_ready_i = 1'b0;
                                    stalls++;
                                end else begin
                                    ps_ready_i = 1'b1;
                                    seen_out   = 1'b1;
                                end
                            end else begin
                                ps_ready_i = 1'b1;
                            end
                        end
                        default: ps_ready_i = 1'b1;
                    endcase
                    if (ps_valid_o && ps_ready_i) begin
                        got_data.push_back(int'(ps_data_o));
                        got_last.push_back(ps_last_o);
                        got_cyc.push_back(cyc);
                    end
                    if (done_o) begin
                        done_cnt++;
                        if (done_cyc < 0) done_cyc = cyc;
                    end
                    if (done_cnt > 0) tail++;
                    if (tail > 3) break;
                    @(negedge clk_i);
                end
                if (done_cnt == 0) timeout = 1'b1;
            end
        join
        ps_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++; if (ps_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ps_valid got %b exp 0", ps_valid_o); end
        checks++; if (ps_last_o !== 1'b0) begin errors++; $display("FAIL reset_ps_last got %b exp 0", ps_last_o); end
        checks++; if (ps_data_o !== '0) begin errors++; $display("FAIL reset_ps_data got %0h exp 0", ps_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
        checks++; if (ovf_err_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_err_o); end
        checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL reset_if_ready got %b exp 0", if_ready_o); end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_stride2();
        int row [$];
        load_filt(0, 1); load_filt(1, 2); load_filt(2, 3);
        do_start(2, 3, 1);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL s2_busy got %b exp 1", busy_o); end
        for (int v = 1; v <= 7; v++) row.push_back(v);
        push_row(row);
        run_job(0, 1'b0);
        checks++; if (timeout) begin errors++; $display("FAIL s2_timeout got 1 exp 0"); end
        checks++; if (got_data.size() != exp_data.size()) begin errors++; $display("FAIL s2_count got %0d exp %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++; if (got_data[i] != exp_data[i]) begin errors++; $display("FAIL s2_data[%0d] got %0d exp %0d", i, got_data[i], exp_data[i]); end
            checks++; if (got_last[i] != exp_last[i]) begin errors++; $display("FAIL s2_last[%0d] got %0d exp %0d", i, got_last[i], exp_last[i]); end
        end
        if (got_cyc.size() > 0) begin
            checks++; if (got_cyc[0] - last_acc_cyc != m_fs + 1) begin errors++; $display("FAIL s2_first_latency got %0d exp %0d", got_cyc[0] - last_acc_cyc, m_fs + 1); end
            checks++; if (done_cyc - got_cyc[got_cyc.size()-1] != 1) begin errors++; $display("FAIL s2_done_latency got %0d exp 1", done_cyc - got_cyc[got_cyc.size()-1]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL s2_done_count got %0d exp 1", done_cnt); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL s2_busy_end got %b exp 0", busy_o); end
    endtask

    task automatic test_stride1();
        int row [$];
        do_start(1, 3, 1);
        write_filt(0, 100);
        for (int v = 1; v <= 7; v++) row.push_back(v);
        push_row(row);
        run_job(0, 1'b0);
        checks++; if (got_data.size() != exp_data.size()) begin errors++; $display("FAIL s1_count got %0d exp %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++; if (got_data[i] != exp_data[i]) begin errors++; $display("FAIL s1_data[%0d] got %0d exp %0d", i, got_data[i], exp_data[i]); end
            checks++; if (got_last[i] != exp_last[i]) begin errors++; $display("FAIL s1_last[%0d] got %0d exp %0d", i, got_last[i], exp_last[i]); end
        end
        for (int i = 0; i + 1 < got_cyc.size(); i++) begin
            checks++; if (got_cyc[i+1] - got_cyc[i] != m_fs + 1) begin errors++; $display("FAIL s1_period[%0d] got %0d exp %0d", i, got_cyc[i+1] - got_cyc[i], m_fs + 1); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL s1_done_count got %0d exp 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int row [$];
        do_start(2, 3, 1);
        for (int v = 1; v <= 7; v++) row.push_back(v);
        push_row(row);
        run_job(2, 1'b0);
        checks++; if (stall_ref != exp_data[0]) begin errors++; $display("FAIL bp_held_data got %0d exp %0d", stall_ref, exp_data[0]); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stability got %0d exp 0", stall_bad); end
        checks++; if (got_data.size() != exp_data.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++; if (got_data[i] != exp_data[i]) begin errors++; $display("FAIL bp_data[%0d] got %0d exp %0d", i, got_data[i], exp_data[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count got %0d exp 1", done_cnt); end
    endtask

    task automatic test_short_row();
        int r0 [$];
        int r1 [$];
        do_start(1, 3, 2);
        r0.push_back(5); r0.push_back(6);
        for (int v = 1; v <= 7; v++) r1.push_back(v);
        push_row(r0);
        push_row(r1);
        run_job(0, 1'b0);
        checks++; if (got_data.size() != exp_data.size()) begin errors++; $display("FAIL short_count got %0d exp %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++; if (got_data[i] != exp_data[i]) begin errors++; $display("FAIL short_data[%0d] got %0d exp %0d", i, got_data[i], exp_data[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL short_done_count got %0d exp 1", done_cnt); end
    endtask

    task automatic test_saturate();
        int row [$];
        int lit;
`ifdef PSUM_SATURATE_EN
        lit = 'hFFFF;
`else
        lit = 2;
`endif
        load_filt(0, 'hFFFF); load_filt(1, 'hFFFF);
        do_start(1, 2, 1);
        row.push_back('hFFFF); row.push_back('hFFFF);
        push_row(row);
        run_job(0, 1'b0);
        checks++; if (got_data.size() != 1) begin errors++; $display("FAIL sat_count got %0d exp 1", got_data.size()); end
        if (got_data.size() > 0) begin
            checks++; if (got_data[0] != exp_data[0]) begin errors++; $display("FAIL sat_model got %0h exp %0h", got_data[0], exp_data[0]); end
            checks++; if (got_data[0] != lit) begin errors++; $display("FAIL sat_value got %0h exp %0h", got_data[0], lit); end
        end
    endtask

    task automatic test_overflow();
        int row [$];
        for (int k = 0; k < 3; k++) load_filt(k, $urandom_range(0, 255));
        do_start(1, 3, 1);
        for (int i = 0; i < 20; i++) row.push_back($urandom_range(0, 255));
        push_row(row);
        run_job(1, 1'b1);
        checks++; if (ovf_err_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf_err_o); end
        checks++; if (got_data.size() != exp_data.size()) begin errors++; $display("FAIL ovf_count got %0d exp %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++; if (got_data[i] != exp_data[i]) begin errors++; $display("FAIL ovf_data[%0d] got %0d exp %0d", i, got_data[i], exp_data[i]); end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < FILTER_MAX; k++) load_filt(k, $urandom_range(0, 65535));
            do_start($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3));
            checks++; if (ovf_err_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_ovf_cleared got %b exp 0", j, ovf_err_o); end
            for (int r = 0; r < m_rows; r++) begin
                int row [$];
                int len;
                for (int g = $urandom_range(0, 2); g > 0; g--)
                    words.push_back({($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00, DATA_W'($urandom)});
                if ($urandom_range(0, 4) == 0) begin
                    words.push_back({2'b10, DATA_W'($urandom)});
                    for (int g = $urandom_range(0, 3); g > 0; g--)
                        words.push_back({2'b00, DATA_W'($urandom)});
                end
                len = $urandom_range(1, 20);
                for (int i = 0; i < len; i++) row.push_back($urandom_range(0, 65535));
                push_row(row);
            end
            run_job(1, 1'b1);
            checks++; if (timeout) begin errors++; $display("FAIL rnd%0d_timeout got 1 exp 0", j); end
            checks++; if (got_data.size() != exp_data.size()) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", j, got_data.size(), exp_data.size()); end
            for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
                checks++; if (got_data[i] != exp_data[i]) begin errors++; $display("FAIL rnd%0d_data[%0d] got %0d exp %0d", j, i, got_data[i], exp_data[i]); end
                checks++; if (got_last[i] != exp_last[i]) begin errors++; $display("FAIL rnd%0d_last[%0d] got %0d exp %0d", j, i, got_last[i], exp_last[i]); end
            end
            checks++; if (ovf_err_o !== exp_ovf) begin errors++; $display("FAIL rnd%0d_ovf got %b exp %b", j, ovf_err_o, exp_ovf); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done_count got %0d exp 1", j, done_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        int n, bad, dones;
        int row [$];
        load_filt(0, 1); load_filt(1, 2); load_filt(2, 3);
        do_start(1, 3, 1);
        for (int v = 1; v <= 7; v++) row.push_back(v);
        push_row(row);
        for (int i = 0; i < words.size(); i++) begin
            if_valid_i = 1'b1;
            if_data_i  = words[i];
            n = 0;
            while (!if_ready_o && n < 50) begin
                @(negedge clk_i);
                n++;
            end
            @(negedge clk_i);
        end
        if_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b exp 1", busy_o); end
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++; if (ps_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_ps_valid got %b exp 0", ps_valid_o); end
        checks++; if (ps_data_o !== '0) begin errors++; $display("FAIL rmid_ps_data got %0h exp 0", ps_data_o); end
        checks++; if (ps_last_o !== 1'b0) begin errors++; $display("FAIL rmid_ps_last got %b exp 0", ps_last_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", done_o); end
        checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_if_ready got %b exp 0", if_ready_o); end
        @(negedge clk_i);
        rst_i      = 1'b1;
        if_valid_i = 1'b1;
        if_data_i  = {2'b10, 16'd9};
        bad = 0; dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (busy_o !== 1'b0 || if_ready_o !== 1'b0) bad++;
            if (done_o) dones++;
        end
        if_valid_i = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL rmid_stays_idle got %0d exp 0", bad); end
        checks++; if (dones != 0) begin errors++; $display("FAIL rmid_no_done got %0d exp 0", dones); end
    endtask

    initial begin
        test_reset();
        test_stride2();
        test_stride1();
        test_backpressure();
        test_short_row();
        test_saturate();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_row_conv_engine.md
# pe_row_conv_engine

Parametrised row-convolution engine for the PE datapath. It accepts a tagged IFMap stream, stores one row in an internal scratchpad and slides a programmable filter across it with configurable stride and filter size. For every complete window it produces one partial sum on a valid/ready output. Row count, stride and filter size are set per job, and backpressure is supported on both input and output.

## Interface
- DATA_W, 16: IFMap and filter element width (unsigned).
- PSUM_W, 16: Psum output width.
- ROW_MAX, 16: IFMap row scratchpad depth.
- FILTER_MAX, 9: filter scratchpad depth.
- STRIDE_W, 3: stride field width.
- FSIZE_W, 4: filter_size field width.
- ROWS_W, 8: num_rows field width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle job start; latches stride, filter_size, num_rows.
- stride  in  STRIDE_W  window step; 0 is treated as 1.
- filter_size  in  FSIZE_W  taps per window; 0 is treated as 1, values above FILTER_MAX clamp to FILTER_MAX.
- num_rows  in  ROWS_W  rows per job; 0 is treated as 1.
- filt_wen  in  1  filter write strobe; ignored while busy.
- filt_addr  in  clog2(FILTER_MAX)  filter tap index.
- filt_data  in  DATA_W  filter tap value.
- if_valid  in  1  IFMap word valid.
- if_ready  out  1  IFMap word accepted when high together with if_valid.
- if_data  in  DATA_W+2  tag in the top 2 bits: 10 = row start, 00 = middle, 01 = row end, 11 = single-element row.
- ps_valid  out  1  psum valid.
- ps_ready  in  1  psum consumer ready.
- ps_data  out  PSUM_W  window psum.
- ps_last  out  1  marks the last psum of a row.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job end.
- ovf_err  out  1  sticky row overflow flag; cleared by start or reset.

## Operation
- States: IDLE, SEEK, LOAD, MAC, OUT, NEXT.
- IDLE:
  - start=1 latches the configuration, clears row_cnt and ovf_err, then moves to SEEK.
  - start=1 is ignored in any other state.
- SEEK:
  - if_ready=1.
  - Words tagged 00 or 01 are consumed and discarded.
  - Tag 10 writes the word at spad[0], sets len=1 and moves to LOAD.
  - Tag 11 writes spad[0], sets len=1 and moves to MAC with base=0.
- LOAD:
  - if_ready=1.
  - Each accepted word is written at spad[len] and len increments.
  - Tag 01 ends the row; move to MAC with base=0.
  - Tag 10 or 11 mid-row discards the partial row and restarts at spad[0] with len=1. Tag 11 then goes directly to MAC.
  - Words arriving when len=ROW_MAX are dropped and set ovf_err; the end tag still terminates the row.
- MAC:
  - Entry rule: if base+fs > len, go to NEXT with no psum emitted (a row shorter than fs yields zero psums).
  - Otherwise: acc cleared on entry, then one tap per cycle, acc += spad[base+k]*filt[k] for k = 0..fs-1, then move to OUT.
- OUT:
  - ps_valid=1; ps_data and ps_last are held stable until ps_ready=1.
  - On the handshake, base += stride and the FSM returns to MAC.
  - ps_last=1 when base+stride+fs > len.
- NEXT:
  - row_cnt increments.
  - If row_cnt equals num_rows: done=1 for one cycle, then IDLE.
  - Otherwise go to SEEK.
- if_ready=0 outside SEEK and LOAD.
- Arithmetic:
  - Internal accumulator width is 2*DATA_W+clog2(FILTER_MAX), so it never overflows internally.
  - ps_data is the low PSUM_W bits of the accumulator (see Configuration).
- Filter writes land only in IDLE; filter contents persist across jobs and are not cleared by reset.

## Timing
- Reset (rst=0 at an edge) forces:
  - State IDLE.
  - ps_valid, ps_last, ps_data, busy, done, ovf_err and if_ready all 0.
  - len, base, row_cnt and acc all 0.
- Reset mid-operation abandons the job; no done pulse is issued.
- busy is 1 from the cycle after start.
- IFMap throughput is one word per cycle.
- First psum appears fs+1 cycles after the cycle the end tag is accepted.
- Window period is fs+1 cycles with ps_ready held high. Each cycle of ps_ready=0 adds one cycle.
- done rises one cycle after the final ps_last handshake (or after the end tag of a row with zero windows).

## Configuration
- PSUM_SATURATE_EN:
  - Defined: if the accumulator exceeds 2^PSUM_W-1, ps_data = all ones.
  - Undefined: ps_data wraps modulo 2^PSUM_W.

## Test plan
- Stride 2, fs=3, filter {1,2,3}, one row 1..7 (tag 10 on the 1, 01 on the 7) -> psums 14, 26, 38; ps_last on 38; done one cycle after it.
- Stride 1, same row and filter -> 14, 20, 26, 32, 38.
- ps_ready held low for 3 cycles during the first OUT -> ps_data stays 14 and if_ready=0 throughout; no psum is lost or duplicated.
- Row of 2 elements with fs=3, num_rows=2, followed by a valid row -> no psum from the first row; second row produces its psums normally; done fires once.
- DATA_W=PSUM_W=16, fs=2, data and filter all 16'hFFFF -> 16'hFFFF with PSUM_SATURATE_EN, 16'h0002 without it.
- 20-word row with ROW_MAX=16 -> ovf_err=1 and psums computed over the first 16 words. Separately, rst=0 asserted during MAC -> all outputs 0 on the next edge and the block stays in IDLE.
